// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: controller state encoding,
// default register-address width and common datapath typedefs.
package pipe_ctrl_pkg;

  // Default width of a register-file address (32 architectural registers).
  localparam int DEFAULT_REG_ADDR_BITS = 5;

  // Datapath word width used by the surrounding core.
  localparam int DATA_BITS = 32;

  // Immediate formats decoded in ID.
  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  // Pipeline controller states.
  typedef enum logic [1:0] {
    RUN,
    WAIT,
    BUBBLE,
    ERROR
  } ctrl_state_e;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: step by one unless already pinned at the maximum.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule : sat_counter

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: freezes the pipe on memory waits, flushes on
// taken branches, inserts a bubble on load-use hazards, and latches a sticky error
// when a memory wait outlasts TIMEOUT cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_BITS = DEFAULT_REG_ADDR_BITS,
  parameter int TIMEOUT       = 1024,
  parameter int CNT_BITS      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_ADDR_BITS-1:0] id_rs1,
  input  logic [REG_ADDR_BITS-1:0] id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [REG_ADDR_BITS-1:0] ex_rd,
  input  logic                     ex_memread,
  input  logic                     ex_branch_taken,
  input  logic                     im_ready,
  input  logic                     dm_req,
  input  logic                     dm_ready,
  output logic                     pc_en,
  output logic                     ifid_en,
  output logic                     idex_en,
  output logic                     exmem_en,
  output logic                     memwb_en,
  output logic                     ifid_flush,
  output logic                     idex_flush,
  output logic                     err,
  output logic [CNT_BITS-1:0]      stall_cnt,
  output logic [CNT_BITS-1:0]      flush_cnt
);

  // Wide enough to hold TIMEOUT-1 for any legal TIMEOUT.
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  ctrl_state_e       state_q;
  ctrl_state_e       state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  logic              mem_wait;
  logic              hazard;
  logic              flush_inc;

  // Memory stall and load-use hazard detection.
  always_comb begin
    mem_wait = (!im_ready) | (dm_req & !dm_ready);
    hazard   = ex_memread & (ex_rd != '0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  // Next state and stage controls; a memory wait freezes everything and defers any
  // pending branch, which re-presents itself from the held EX stage afterwards.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    flush_inc  = 1'b0;
    case (state_q)
      ERROR: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        state_d  = ERROR;
      end
      default: begin
        if (mem_wait) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_en    = 1'b0;
          exmem_en   = 1'b0;
          memwb_en   = 1'b0;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          state_d    = (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) ? ERROR : WAIT;
        end else if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_inc  = 1'b1;
          state_d    = RUN;
        end else if (hazard && (state_q != BUBBLE)) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          state_d    = BUBBLE;
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  // Controller state and wait-length registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign err = (state_q == ERROR);

  sat_counter #(.WIDTH(CNT_BITS)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_BITS)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver applies stimulus and pushes the expected
// cycle response from a behavioural model; a monitor pops and compares mid-cycle.
module tb_pipe_ctrl;

  localparam int RAB = 5;
  localparam int TO  = 8;
  localparam int CB  = 4;
  localparam int CNT_MAX = (1 << CB) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [RAB-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic           id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic           ex_memread = 1'b0, ex_branch_taken = 1'b0;
  logic           im_ready = 1'b1, dm_req = 1'b0, dm_ready = 1'b0;
  logic           pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic           ifid_flush, idex_flush, err;
  logic [CB-1:0]  stall_cnt, flush_cnt;

  pipe_ctrl #(.REG_ADDR_BITS(RAB), .TIMEOUT(TO), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .im_ready(im_ready), .dm_req(dm_req), .dm_ready(dm_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] ctrl;   // {pc,ifid,idex,exmem,memwb enables, ifid_flush, idex_flush}
    logic       err;
    int         stall;
    int         flush;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: consecutive wait count, "just stalled for a load" flag,
  // sticky error and the two saturating event counts.
  int m_waits, m_stall, m_flush;
  bit m_err, m_bubble;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_waits = 0; m_stall = 0; m_flush = 0; m_err = 0; m_bubble = 0;
  endtask

  // Apply one cycle of inputs, predict the response, then let the edge happen.
  task automatic drive(input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit mr, input bit br,
                       input bit imr, input bit dreq, input bit drdy);
    exp_t e;
    bit   mw, hz;
    id_rs1 = RAB'(rs1); id_rs2 = RAB'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = RAB'(rd); ex_memread = mr; ex_branch_taken = br;
    im_ready = imr; dm_req = dreq; dm_ready = drdy;
    e.err   = m_err;
    e.stall = m_stall;
    e.flush = m_flush;
    mw = !imr || (dreq && !drdy);
    hz = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (m_err) begin
      e.ctrl  = 7'b00000_00;
      m_stall = sat_inc(m_stall);
    end else if (mw) begin
      e.ctrl   = 7'b00000_00;
      m_stall  = sat_inc(m_stall);
      m_waits  = m_waits + 1;
      m_bubble = 0;
      if (m_waits >= TO) m_err = 1;
    end else if (br) begin
      e.ctrl   = 7'b11111_11;
      m_flush  = sat_inc(m_flush);
      m_waits  = 0;
      m_bubble = 0;
    end else if (hz && !m_bubble) begin
      e.ctrl   = 7'b00111_01;
      m_stall  = sat_inc(m_stall);
      m_waits  = 0;
      m_bubble = 1;
    end else begin
      e.ctrl   = 7'b11111_00;
      m_waits  = 0;
      m_bubble = 0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  // Asynchronous reset: registers must clear before any clock edge arrives.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    model_reset();
    #1;
    check({tag, "_rst_stall"}, 32'(stall_cnt), 0);
    check({tag, "_rst_flush"}, 32'(flush_cnt), 0);
    check({tag, "_rst_err"}, 32'(err), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compares the predicted response mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctrl", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}),
              32'(e.ctrl));
        check("err", 32'(err), 32'(e.err));
        check("stall_cnt", 32'(stall_cnt), 32'(e.stall));
        check("flush_cnt", 32'(flush_cnt), 32'(e.flush));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #2;
    check("init_stall", 32'(stall_cnt), 0);
    check("init_flush", 32'(flush_cnt), 0);
    check("init_err", 32'(err), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Load-use hazard: one stall cycle, then the bubble cycle proceeds normally.
    drive(5, 0, 1, 0, 5, 1, 0, 1, 0, 0);
    drive(5, 0, 1, 0, 5, 1, 0, 1, 0, 0);
    idle(1);
    check("lu_stall", 32'(stall_cnt), 1);

    // Same pattern with x0 as destination: no stall.
    drive(0, 0, 1, 0, 0, 1, 0, 1, 0, 0);
    idle(1);
    check("x0_stall", 32'(stall_cnt), 1);

    // Hazard through rs2 only.
    drive(1, 7, 1, 1, 7, 1, 0, 1, 0, 0);
    drive(1, 7, 1, 1, 7, 1, 0, 1, 0, 0);
    check("rs2_stall", 32'(stall_cnt), 2);

    // Branch beats hazard.
    do_reset("br");
    drive(5, 0, 1, 0, 5, 1, 1, 1, 0, 0);
    check("br_flush", 32'(flush_cnt), 1);
    check("br_stall", 32'(stall_cnt), 0);

    // Data-memory wait with a pending branch: frozen 3 cycles, flushed once on cycle 4.
    do_reset("dmw");
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    check("dmw_flush0", 32'(flush_cnt), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    check("dmw_flush", 32'(flush_cnt), 1);
    check("dmw_stall", 32'(stall_cnt), 3);
    idle(2);

    // Timeout: 8 consecutive fetch waits reach ERROR, which is sticky.
    do_reset("to");
    for (int i = 0; i < TO - 1; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("to_err_early", 32'(err), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("to_err", 32'(err), 1);
    idle(12);
    check("to_err_sticky", 32'(err), 1);
    check("to_stall_sat", 32'(stall_cnt), CNT_MAX);

    // Reset while mid-wait discards everything.
    do_reset("mw");
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mw_stall", 32'(stall_cnt), 3);
    do_reset("mw2");
    idle(1);

    // Stall counter saturation via repeated load-use stalls.
    for (int i = 0; i < 20; i++) begin
      drive(3, 0, 1, 0, 3, 1, 0, 1, 0, 0);
      drive(3, 0, 1, 0, 3, 1, 0, 1, 0, 0);
    end
    check("lu_stall_sat", 32'(stall_cnt), CNT_MAX);

    // Randomized traffic with periodic resets.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset("rnd");
      for (int i = 0; i < 100; i++) begin
        drive($urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_ctrl

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter REG_ADDR_BITS, default 5, register-address width.
REQ-002 Parameter TIMEOUT, default 1024, maximum consecutive memory-wait cycles before error.
REQ-003 Parameter CNT_BITS, default 32, performance-counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 id_rs1, id_rs2  in  REG_ADDR_BITS each  source registers of the instruction in ID.
REQ-007 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads that source.
REQ-008 ex_rd  in  REG_ADDR_BITS  destination of the instruction in EX.
REQ-009 ex_memread  in  1  EX instruction is a load.
REQ-010 ex_branch_taken  in  1  EX resolved a taken branch or jump.
REQ-011 im_ready  in  1  instruction memory delivers the fetch this cycle.
REQ-012 dm_req, dm_ready  in  1 each  MEM-stage data access pending / completed.
REQ-013 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage-register write enables.
REQ-014 ifid_flush, idex_flush  out  1 each  load a bubble into that stage register.
REQ-015 err  out  1  sticky memory-timeout flag.
REQ-016 stall_cnt, flush_cnt  out  CNT_BITS each  performance counters.

Function
REQ-017 mem_wait SHALL equal (!im_ready) | (dm_req & !dm_ready).
REQ-018 hazard SHALL equal ex_memread & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
REQ-019 FSM states SHALL be RUN, WAIT, BUBBLE, ERROR; control outputs combinational from state and inputs.
REQ-020 Priority in RUN, WAIT, BUBBLE: mem_wait > ex_branch_taken > hazard > normal.
REQ-021 mem_wait: all enables 0, both flushes 0; next state WAIT.
REQ-022 Branch (no mem_wait): all enables 1, ifid_flush=1, idex_flush=1; next RUN; flush_cnt +1.
REQ-023 Hazard in RUN (no mem_wait, no branch): pc_en=0, ifid_en=0, idex_flush=1, remaining enables 1; next BUBBLE.
REQ-024 BUBBLE: hazard term ignored; otherwise as RUN; next RUN unless mem_wait or branch rule applies.
REQ-025 Normal: all enables 1, flushes 0; next RUN.
REQ-026 WAIT: same output rules as RUN; wait_cnt increments each cycle mem_wait holds, cleared on leaving WAIT.
REQ-027 mem_wait still 1 with wait_cnt == TIMEOUT-1: next state ERROR, err set.
REQ-028 ERROR: all enables 0, flushes 0, err=1, exit only by reset.
REQ-029 Branch with mem_wait: freeze wins; EX is held, so the branch re-asserts and is flushed on the first non-waiting cycle; counted once.
REQ-030 stall_cnt +1 every cycle pc_en==0 (includes ERROR); both counters saturate at all-ones.

Reset
REQ-031 Reset asserted: state=RUN, wait_cnt=0, err=0, stall_cnt=0, flush_cnt=0 immediately, independent of clk.
REQ-032 Reset mid-WAIT or in ERROR SHALL discard all state; first post-reset cycle evaluated as RUN.

Structure
REQ-033 State enum and REG_ADDR_BITS default SHALL reside in the shared definitions package alongside DATA_BITS/IMM_TYPE.
REQ-034 One sub-module, sat_counter (width parameter, inc, saturating), instantiated for stall_cnt and flush_cnt.

Verification
REQ-035 ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_en=0, ifid_en=0, idex_flush=1 one cycle, then BUBBLE, stall_cnt=1.
REQ-036 Same as REQ-035 with ex_rd=0 -> no stall, all enables 1.
REQ-037 ex_branch_taken=1 with hazard=1 -> ifid_flush=idex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
REQ-038 dm_req=1, dm_ready=0 for 3 cycles with ex_branch_taken=1 -> enables 0 for 3 cycles, flush on cycle 4, flush_cnt=1, stall_cnt=3.
REQ-039 TIMEOUT=8, im_ready=0 held -> err=1 after cycle 8, enables stay 0 after im_ready=1, cleared only by rst=0.
REQ-040 CNT_BITS=4, 20 stall cycles -> stall_cnt saturates at 15; async rst=0 mid-WAIT -> counters 0 before next edge.
